// File: rtl/prbs15_lock_ctrl_if.sv
// Byte-stream and status bundle between the loopback capture path, the lock
// controller and the readout register bank.
interface prbs15_lock_ctrl_if #(parameter int CW = 32);
   logic          enable;
   logic [7:0]    rx_byte;
   logic          rx_valid;
   logic          clear_counters;
   logic [1:0]    state;
   logic          locked;
   logic          lock_lost;
   logic [CW-1:0] byte_cnt;
   logic [CW-1:0] err_byte_cnt;
   logic [CW-1:0] err_bit_cnt;
   logic          cnt_sat;

   modport master (
      output enable, rx_byte, rx_valid, clear_counters,
      input  state, locked, lock_lost, byte_cnt, err_byte_cnt, err_bit_cnt, cnt_sat
   );

   modport slave (
      input  enable, rx_byte, rx_valid, clear_counters,
      output state, locked, lock_lost, byte_cnt, err_byte_cnt, err_bit_cnt, cnt_sat
   );
endinterface

// File: rtl/prbs15_lock_ctrl.sv
// PRBS15 (x^15+x^14+1) loopback checker: self-seeded byte predictor plus a
// SEARCH/LOCKED controller with saturating statistics counters.
module prbs15_byte (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   output logic [7:0] prbs_out
);
   // Last two received bytes, oldest serial bit at [15]; bit 7 of a byte is sent first.
   logic [15:0] hist;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) hist <= '0;
      else        hist <= {hist[7:0], data_in};

   // s[n] = s[n-14] ^ s[n-15]; every tap of the next byte lies inside hist.
   always_comb begin
      prbs_out = '0;
      for (int i = 0; i < 8; i++)
         prbs_out[7-i] = hist[13-i] ^ hist[14-i];
   end
endmodule

module prbs15_lock_ctrl #(
   parameter int LOCK_COUNT   = 16,
   parameter int UNLOCK_COUNT = 4,
   parameter int CW           = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   prbs15_lock_ctrl_if.slave     bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;

   state_t        st;
   logic          locked_q, lock_lost_q, cnt_sat_q;
   logic [CW-1:0] byte_q, err_byte_q, err_bit_q;
   logic [CW-1:0] byte_nxt, err_byte_nxt, err_bit_nxt;
   logic [CW:0]   bit_sum;
   logic [7:0]    good_run, bad_run;
   logic [1:0]    vld_hist;
   logic [7:0]    pred, mismatch;
   logic [3:0]    nbits;
   logic          cmp_ok, errored, count_en, sat_nxt;

   prbs15_byte u_pred (.clk(clk), .rst_n(rst_n), .data_in(bus.rx_byte), .prbs_out(pred));

   // A prediction is only trustworthy when both seeding bytes were valid too.
   assign cmp_ok   = bus.rx_valid & vld_hist[0] & vld_hist[1];
   assign mismatch = pred ^ bus.rx_byte;
   assign errored  = |mismatch;
   assign count_en = bus.enable & cmp_ok & (st == LOCKED);

   always_comb begin
      nbits = '0;
      for (int i = 0; i < 8; i++)
         nbits = nbits + {3'b000, mismatch[i]};
   end

   always_comb begin
      byte_nxt     = byte_q;
      err_byte_nxt = err_byte_q;
      err_bit_nxt  = err_bit_q;
      bit_sum      = {1'b0, err_bit_q} + {{(CW-3){1'b0}}, nbits};
      if (count_en) begin
         if (~&byte_q) byte_nxt = byte_q + CW'(1);
         if (errored) begin
            if (~&err_byte_q) err_byte_nxt = err_byte_q + CW'(1);
            err_bit_nxt = bit_sum[CW] ? '1 : bit_sum[CW-1:0];
         end
      end
   end

   assign sat_nxt = cnt_sat_q | (&byte_nxt) | (&err_byte_nxt) | (&err_bit_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= IDLE;
         locked_q    <= 1'b0;
         lock_lost_q <= 1'b0;
         cnt_sat_q   <= 1'b0;
         byte_q      <= '0;
         err_byte_q  <= '0;
         err_bit_q   <= '0;
         good_run    <= '0;
         bad_run     <= '0;
         vld_hist    <= '0;
      end else begin
         vld_hist    <= {vld_hist[0], bus.rx_valid};
         lock_lost_q <= 1'b0;
         if (bus.clear_counters) begin
            byte_q     <= '0;
            err_byte_q <= '0;
            err_bit_q  <= '0;
            cnt_sat_q  <= 1'b0;
         end else begin
            byte_q     <= byte_nxt;
            err_byte_q <= err_byte_nxt;
            err_bit_q  <= err_bit_nxt;
            cnt_sat_q  <= sat_nxt;
         end
         if (!bus.enable) begin
            st       <= IDLE;
            locked_q <= 1'b0;
         end else begin
            case (st)
               IDLE: begin
                  st       <= SEARCH;
                  good_run <= '0;
                  bad_run  <= '0;
               end
               SEARCH: if (cmp_ok) begin
                  if (errored)
                     good_run <= '0;
                  else if (good_run == 8'(LOCK_COUNT - 1)) begin
                     st       <= LOCKED;
                     locked_q <= 1'b1;
                     good_run <= '0;
                     bad_run  <= '0;
                  end else
                     good_run <= good_run + 8'd1;
               end
               LOCKED: if (cmp_ok) begin
                  if (!errored)
                     bad_run <= '0;
                  else if (bad_run == 8'(UNLOCK_COUNT - 1)) begin
                     st          <= SEARCH;
                     locked_q    <= 1'b0;
                     lock_lost_q <= 1'b1;
                     good_run    <= '0;
                     bad_run     <= '0;
                  end else
                     bad_run <= bad_run + 8'd1;
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

   assign bus.state        = st;
   assign bus.locked       = locked_q;
   assign bus.lock_lost    = lock_lost_q;
   assign bus.byte_cnt     = byte_q;
   assign bus.err_byte_cnt = err_byte_q;
   assign bus.err_bit_cnt  = err_bit_q;
   assign bus.cnt_sat      = cnt_sat_q;
endmodule
